// File: rtl/mem_serial_reader_if.sv
// Bus bundle for mem_serial_reader: array write port, frame control and
// the 1-bit serial output stream with its valid/ready handshake.
//
// Serial handshake: ser_valid says ser_out/ser_last hold a bit; the bit
// transfers on a rising edge where ser_valid && ser_ready. While ser_valid
// is high and ser_ready is low the producer holds ser_out and ser_last
// stable. ser_ready may change freely; it never depends on ser_valid.
interface mem_serial_reader_if #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_last;
  logic             done;
  logic [1:0]       fsm_state;

  // master: the surrounding logic / bench; slave: the reader itself
  modport master (
    output wr_en, wr_addr, wr_data, start, ser_ready,
    input  busy, ser_out, ser_valid, ser_last, done, fsm_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, ser_ready,
    output busy, ser_out, ser_valid, ser_last, done, fsm_state
  );
endinterface

// File: rtl/mem_serial_reader.sv
// mem_serial_reader: DEPTH x WIDTH array that, on start, streams every word
// from address 0 upward MSB first over a 1-bit valid/ready interface.
// Optional feature macro: PARITY_EN appends an even-parity bit to each word
// (ser_last then marks the parity bit).
// fsm_state on the bus exposes the FSM encoding (IDLE/LOAD/SHIFT/DONE = 0..3).
module mem_serial_reader #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_serial_reader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int CW = $clog2(SW + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_INIT  = CW'(SW - 1);

  logic [1:0]       state;
  logic [AW-1:0]    addr;
  logic [CW-1:0]    bitcnt;
  logic [SW-1:0]    shreg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_word;
  logic [SW-1:0]    load_val;
  logic             xfer;
  logic             word_end;

  assign rd_word = mem[addr];
`ifdef PARITY_EN
  assign load_val = {rd_word, ^rd_word};
`else
  assign load_val = rd_word;
`endif

  assign xfer     = (state == S_SHIFT) && bus.ser_ready;
  assign word_end = xfer && (bitcnt == '0);

  // Array write port: not reset, so contents survive rst_n; the FSM reads
  // the pre-edge value, giving read-before-write on a same-cycle LOAD.
  always_ff @(posedge clk) begin
    if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Frame FSM with address, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      addr   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr  <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg  <= load_val;
          bitcnt <= CNT_INIT;
          state  <= S_SHIFT;
        end
        S_SHIFT: begin
          if (xfer) begin
            shreg <= shreg << 1;
            if (word_end) begin
              if (addr == LAST_ADDR) begin
                state <= S_DONE;
              end else begin
                addr  <= addr + 1'b1;
                state <= S_LOAD;
              end
            end else begin
              bitcnt <= bitcnt - 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode directly from state so reset clears them without a clock.
  assign bus.busy      = (state != S_IDLE);
  assign bus.ser_valid = (state == S_SHIFT);
  assign bus.ser_out   = bus.ser_valid & shreg[SW-1];
  assign bus.ser_last  = bus.ser_valid && (bitcnt == '0);
  assign bus.done      = (state == S_DONE);
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_mem_serial_reader.sv
// Bench for mem_serial_reader (WIDTH=3, DEPTH=2). Also valid with PARITY_EN.
module tb_mem_serial_reader;
  localparam int WIDTH = 3;
  localparam int DEPTH = 2;
  localparam int AW    = $clog2(DEPTH);
`ifdef PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int CPW      = NB + 1;
  localparam int DONE_CYC = 1 + DEPTH * CPW;

  logic clk;
  logic rst_n;
  mem_serial_reader_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  mem_serial_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [1:0]       exp_q[$];
  logic [1:0]       obs_q[$];
  int               obs_cyc[$];
  logic [1:0]       stall_q[$];
  int               done_q[$];
  int               busy_fall;
  int               noise;
  logic [4:0]       pre_rst;
  logic [4:0]       post_rst;

  int               stall_from;
  int               stall_len;
  int               rs_cyc [2];
  int               ev_cyc [2];
  logic [AW-1:0]    ev_addr [2];
  logic [WIDTH-1:0] ev_data [2];
  int               rst_cyc;

  // driver tasks
  task automatic clear_knobs();
    stall_from = -1; stall_len = 0;
    rs_cyc[0] = -1; rs_cyc[1] = -1;
    ev_cyc[0] = -1; ev_cyc[1] = -1;
    rst_cyc = -1;
    obs_q.delete(); obs_cyc.delete(); stall_q.delete(); done_q.delete();
    exp_q.delete();
    busy_fall = -1; noise = 0;
  endtask

  task automatic write_word(input int a, input logic [WIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a[AW-1:0];
    bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int b = 0; b < NB; b++) begin
      logic bitv;
      if (b < WIDTH) bitv = w[WIDTH-1-b];
      else           bitv = ^w;
      exp_q.push_back({(b == NB - 1), bitv});
    end
  endtask

  // Cycle c is the clock period whose closing edge samples the inputs set
  // here; start is raised in cycle 0 so it is sampled at edge 0.
  task automatic run_frame(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      bus.start     = (c == 0) || (c == rs_cyc[0]) || (c == rs_cyc[1]);
      bus.ser_ready = !((c >= stall_from) && (c < stall_from + stall_len));
      bus.wr_en     = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (c == ev_cyc[k]) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = ev_addr[k];
          bus.wr_data = ev_data[k];
        end
      end
      if (c == rst_cyc) begin
        #2;
        pre_rst = {bus.ser_valid, bus.busy, bus.done, bus.ser_out, bus.ser_last};
        rst_n = 1'b0;
        #1;
        post_rst = {bus.ser_valid, bus.busy, bus.done, bus.ser_out, bus.ser_last};
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.ser_ready = 1'b1;
        return;
      end
      @(negedge clk);
      if (bus.ser_valid && bus.ser_ready) begin
        obs_q.push_back({bus.ser_last, bus.ser_out});
        obs_cyc.push_back(c);
      end
      if (bus.ser_valid && !bus.ser_ready) stall_q.push_back({bus.ser_last, bus.ser_out});
      if (!bus.ser_valid && (bus.ser_out || bus.ser_last)) noise++;
      if (bus.done) done_q.push_back(c);
      if (done_q.size() > 0 && !bus.done && !bus.busy && busy_fall < 0) busy_fall = c;
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.wr_en = 1'b0; bus.ser_ready = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    logic [4:0] snap;
    snap = {bus.ser_valid, bus.busy, bus.done, bus.ser_out, bus.ser_last};
    checks++;
    if (snap !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", snap);
    end
    checks++;
    if (bus.fsm_state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", bus.fsm_state);
    end
    rst_n = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    snap = {bus.ser_valid, bus.busy, bus.done, bus.ser_out, bus.ser_last};
    checks++;
    if (snap !== 5'b0) begin
      errors++; $display("FAIL idle_outputs: got %b want 00000", snap);
    end
  endtask

  task automatic test_basic();
    int i;
    logic [1:0] e, g;
    write_word(0, 3'b111);
    write_word(1, 3'b101);
    clear_knobs();
    push_word(model_mem[0]);
    push_word(model_mem[1]);
    run_frame(DONE_CYC + 3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    i = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL basic_bit%0d: got last,bit=%b want %b", i, g, e);
      end
      checks++;
      if (obs_cyc[i] != 2 + (i / NB) * CPW + (i % NB)) begin
        errors++; $display("FAIL basic_cycle%0d: got %0d want %0d", i, obs_cyc[i], 2 + (i / NB) * CPW + (i % NB));
      end
      i++;
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != DONE_CYC) begin
      errors++; $display("FAIL basic_done: got %0d pulses first at %0d want 1 at %0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, DONE_CYC);
    end
    checks++;
    if (busy_fall != DONE_CYC + 1) begin
      errors++; $display("FAIL basic_busy_fall: got %0d want %0d", busy_fall, DONE_CYC + 1);
    end
    checks++;
    if (noise != 0) begin
      errors++; $display("FAIL basic_idle_noise: got %0d want 0", noise);
    end
  endtask

  task automatic test_stall();
    logic [1:0] e, g, held;
    clear_knobs();
    push_word(model_mem[0]);
    push_word(model_mem[1]);
    held = exp_q[1];
    stall_from = 3; stall_len = 3;
    run_frame(DONE_CYC + 6);
    checks++;
    if (stall_q.size() != 3) begin
      errors++; $display("FAIL stall_cycles: got %0d want 3", stall_q.size());
    end
    while (stall_q.size() > 0) begin
      g = stall_q.pop_front();
      checks++;
      if (g !== held) begin
        errors++; $display("FAIL stall_hold: got last,bit=%b want %b", g, held);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL stall_bit: got last,bit=%b want %b", g, e);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != DONE_CYC + 3) begin
      errors++; $display("FAIL stall_done: got %0d pulses first at %0d want 1 at %0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, DONE_CYC + 3);
    end
  endtask

  task automatic test_restart();
    logic [1:0] e, g;
    clear_knobs();
    push_word(model_mem[0]);
    push_word(model_mem[1]);
    rs_cyc[0] = 3;
    rs_cyc[1] = DONE_CYC;
    run_frame(DONE_CYC + 5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL restart_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL restart_bit: got last,bit=%b want %b", g, e);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != DONE_CYC) begin
      errors++; $display("FAIL restart_done: got %0d pulses first at %0d want 1 at %0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, DONE_CYC);
    end
    checks++;
    if (busy_fall != DONE_CYC + 1) begin
      errors++; $display("FAIL restart_busy_fall: got %0d want %0d", busy_fall, DONE_CYC + 1);
    end
  endtask

  task automatic test_midframe_write();
    logic [1:0] e, g;
    clear_knobs();
    push_word(model_mem[0]);
    ev_cyc[0] = 1; ev_addr[0] = 1'b0; ev_data[0] = 3'b000;
    ev_cyc[1] = 3; ev_addr[1] = 1'b1; ev_data[1] = 3'b010;
    model_mem[0] = 3'b000;
    model_mem[1] = 3'b010;
    push_word(model_mem[1]);
    run_frame(DONE_CYC + 3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midwrite_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL midwrite_bit: got last,bit=%b want %b", g, e);
      end
    end
    // follow-up frame shows both writes landed
    clear_knobs();
    push_word(model_mem[0]);
    push_word(model_mem[1]);
    run_frame(DONE_CYC + 3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midwrite_after_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL midwrite_after_bit: got last,bit=%b want %b", g, e);
      end
    end
  endtask

  task automatic test_start_write();
    logic [1:0] e, g;
    clear_knobs();
    ev_cyc[0] = 0; ev_addr[0] = 1'b0; ev_data[0] = 3'b011;
    model_mem[0] = 3'b011;
    push_word(model_mem[0]);
    push_word(model_mem[1]);
    run_frame(DONE_CYC + 3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL startwrite_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL startwrite_bit: got last,bit=%b want %b", g, e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [1:0] e, g;
    logic [4:0] snap;
    write_word(0, 3'b111);
    write_word(1, 3'b110);
    clear_knobs();
    rst_cyc = 2 + CPW + 1;
    run_frame(DONE_CYC + 3);
    checks++;
    if (pre_rst !== 5'b11010) begin
      errors++; $display("FAIL rst_pre: got valid,busy,done,out,last=%b want 11010", pre_rst);
    end
    checks++;
    if (post_rst !== 5'b00000) begin
      errors++; $display("FAIL rst_async: got valid,busy,done,out,last=%b want 00000", post_rst);
    end
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    snap = {bus.ser_valid, bus.busy, bus.done, bus.ser_out, bus.ser_last};
    checks++;
    if (snap !== 5'b0 || bus.fsm_state !== 2'd0) begin
      errors++; $display("FAIL rst_release: got %b state %0d want 00000 state 0", snap, bus.fsm_state);
    end
    clear_knobs();
    push_word(model_mem[0]);
    push_word(model_mem[1]);
    run_frame(DONE_CYC + 3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_frame_count: got %0d bits want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); g = obs_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL rst_frame_bit: got last,bit=%b want %b", g, e);
      end
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != DONE_CYC) begin
      errors++; $display("FAIL rst_frame_done: got %0d pulses first at %0d want 1 at %0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, DONE_CYC);
    end
  endtask

  // sequence and final report
  initial begin
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.ser_ready = 1'b1;
    clear_knobs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_midframe_write();
    test_start_write();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
